// File: rtl/mem_stage_ctrl_if.sv
// ============================================================================
// Module   : mem_stage_ctrl_if
// Brief    : Data-cache request/response bus between the memory stage and dcache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic              dhit;
  logic [DATA_W-1:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : MEM-stage controller: issues dcache requests, stalls until dhit,
//            drives the MEM/WB bundle, tracks halt and counts wait cycles.
//            Optional load-linked/store-conditional support under `LL_SC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WSEL_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ex_valid,
  input  logic              ex_dREN,
  input  logic              ex_dWEN,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_store,
  input  logic              ex_halt,
  input  logic              ex_WEN,
  input  logic [WSEL_W-1:0] ex_wsel,
  input  logic [1:0]        ex_wdatsel,
  input  logic [DATA_W-1:0] ex_lui_word,
  input  logic [DATA_W-1:0] ex_npc,
  mem_stage_ctrl_if.master  dbus,
  output logic [DATA_W-1:0] wb_port_o,
  output logic [DATA_W-1:0] wb_dmemload,
  output logic [DATA_W-1:0] wb_lui_word,
  output logic [DATA_W-1:0] wb_npc,
  output logic [WSEL_W-1:0] wb_wsel,
  output logic [1:0]        wb_wdatsel,
  output logic              wb_WEN,
  output logic              wb_halt,
  output logic              memwb_enable,
  output logic              mem_stall,
  output logic              halted,
  output logic [CNT_W-1:0]  wait_cycles
`ifdef LL_SC_EN
  ,
  input  logic              ex_ll,
  input  logic              ex_sc,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr
`endif
);

  localparam logic [1:0] PORT_O = 2'd0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state, state_n;
  logic              mem_op;
  logic              sc_fail;
  logic              ren;
  logic              wen;
  logic [DATA_W-1:0] port_o_val;

`ifdef LL_SC_EN
  logic              link_valid;
  logic [ADDR_W-1:0] link_addr;
  logic              sc_ok;
  logic              ll_done;
  logic              store_retire;

  assign sc_ok      = link_valid & (link_addr == ex_addr);
  assign sc_fail    = ex_valid & ex_sc & ~sc_ok;
  assign port_o_val = ex_sc ? {{(DATA_W-1){1'b0}}, sc_ok} : DATA_W'(ex_addr);
`else
  assign sc_fail    = 1'b0;
  assign port_o_val = DATA_W'(ex_addr);
`endif

  // nRST gates the strobes so an in-flight access is abandoned the instant reset asserts
  assign mem_op = nRST & ex_valid & (ex_dREN | ex_dWEN) & ~halted & ~sc_fail;
  assign wen    = mem_op & ex_dWEN;
  assign ren    = mem_op & ex_dREN & ~ex_dWEN;

  assign dbus.dmemREN   = ren;
  assign dbus.dmemWEN   = wen;
  assign dbus.dmemaddr  = ex_addr;
  assign dbus.dmemstore = ex_store;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    memwb_enable = nRST;
    mem_stall    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !dbus.dhit) begin
          memwb_enable = 1'b0;
          mem_stall    = 1'b1;
          state_n      = WAIT;
        end
      end
      WAIT: begin
        if (mem_op && !dbus.dhit) begin
          memwb_enable = 1'b0;
          mem_stall    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign wb_port_o   = nRST ? port_o_val : '0;
  assign wb_dmemload = (mem_op && dbus.dhit) ? dbus.dmemload : '0;
  assign wb_lui_word = nRST ? ex_lui_word : '0;
  assign wb_npc      = nRST ? ex_npc : '0;
  assign wb_wsel     = nRST ? ex_wsel : '0;
  assign wb_wdatsel  = nRST ? ex_wdatsel : PORT_O;
  assign wb_WEN      = nRST & ex_valid & ex_WEN & ~halted;
  assign wb_halt     = nRST & (halted | (ex_valid & ex_halt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halted      <= 1'b0;
      wait_cycles <= '0;
    end else begin
      if (memwb_enable && wb_halt) halted <= 1'b1;
      if (mem_stall && !(&wait_cycles)) wait_cycles <= wait_cycles + CNT_W'(1);
    end
  end

`ifdef LL_SC_EN
  assign ll_done      = ren & ex_ll & dbus.dhit;
  assign store_retire = memwb_enable & ex_valid & ~halted & ex_dWEN;

  // A snoop to the address being linked this cycle prevents the link from forming
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (ll_done) begin
      link_valid <= ~(snoop_inv & (snoop_addr == ex_addr));
      link_addr  <= ex_addr;
    end else if (store_retire || (snoop_inv && snoop_addr == link_addr)) begin
      link_valid <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Brief    : Self-checking bench for mem_stage_ctrl (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ex_valid, ex_dREN, ex_dWEN, ex_halt, ex_WEN;
  logic [31:0] ex_addr, ex_store, ex_lui_word, ex_npc;
  logic [4:0]  ex_wsel;
  logic [1:0]  ex_wdatsel;
  logic [31:0] wb_port_o, wb_dmemload, wb_lui_word, wb_npc;
  logic [4:0]  wb_wsel;
  logic [1:0]  wb_wdatsel;
  logic        wb_WEN, wb_halt, memwb_enable, mem_stall, halted;
  logic [31:0] wait_cycles;
`ifdef LL_SC_EN
  logic        ex_ll, ex_sc, snoop_inv;
  logic [31:0] snoop_addr;
`endif

  mem_stage_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dbus ();

  mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32), .WSEL_W(5), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
    .ex_addr(ex_addr), .ex_store(ex_store), .ex_halt(ex_halt), .ex_WEN(ex_WEN),
    .ex_wsel(ex_wsel), .ex_wdatsel(ex_wdatsel), .ex_lui_word(ex_lui_word), .ex_npc(ex_npc),
    .dbus(dbus.master),
    .wb_port_o(wb_port_o), .wb_dmemload(wb_dmemload), .wb_lui_word(wb_lui_word),
    .wb_npc(wb_npc), .wb_wsel(wb_wsel), .wb_wdatsel(wb_wdatsel), .wb_WEN(wb_WEN),
    .wb_halt(wb_halt), .memwb_enable(memwb_enable), .mem_stall(mem_stall),
    .halted(halted), .wait_cycles(wait_cycles)
`ifdef LL_SC_EN
    , .ex_ll(ex_ll), .ex_sc(ex_sc), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid, ren, wen, halt, rfwen, hit;
    logic [4:0]  wsel;
    logic [1:0]  wdatsel;
    logic [31:0] addr, store, load;
    logic        e_ren, e_wen, e_en, e_stall, e_wbwen, e_wbhalt;
    logic [31:0] e_load;
  } vec_t;

  vec_t        vecs[7];
  vec_t        sb_q[$];
  logic [31:0] ld_q[$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v, r, w, h, rw, input logic [4:0] ws, input logic [1:0] wd,
    input logic [31:0] a, s, input logic hi, input logic [31:0] ld,
    input logic er, ew, een, est, ewb, eh, input logic [31:0] el);
    vec_t t;
    t.valid = v; t.ren = r; t.wen = w; t.halt = h; t.rfwen = rw; t.wsel = ws;
    t.wdatsel = wd; t.addr = a; t.store = s; t.hit = hi; t.load = ld;
    t.e_ren = er; t.e_wen = ew; t.e_en = een; t.e_stall = est; t.e_wbwen = ewb;
    t.e_wbhalt = eh; t.e_load = el;
    return t;
  endfunction

  task automatic clr_ex();
    ex_valid = 0; ex_dREN = 0; ex_dWEN = 0; ex_halt = 0; ex_WEN = 0;
    ex_addr = 0; ex_store = 0; ex_wsel = 0; ex_wdatsel = 0;
    ex_lui_word = 0; ex_npc = 0; dbus.dhit = 0; dbus.dmemload = 0;
`ifdef LL_SC_EN
    ex_ll = 0; ex_sc = 0; snoop_inv = 0; snoop_addr = 0;
`endif
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    bit   got;

    // valid ren wen halt rfwen wsel wds addr store hit load | ren wen en stall wbwen wbhalt load
    vecs[0] = mk(1,0,0,0,1, 5'd3, 2'd0, 32'h10,  32'h0,    0, 32'h0,        0,0,1,0,1,0, 32'h0);
    vecs[1] = mk(0,1,0,1,1, 5'd7, 2'd1, 32'h20,  32'h0,    0, 32'h0,        0,0,1,0,0,0, 32'h0);
    vecs[2] = mk(1,0,1,0,0, 5'd0, 2'd0, 32'h40,  32'h1234, 1, 32'h55,       0,1,1,0,0,0, 32'h55);
    vecs[3] = mk(1,1,0,0,1, 5'd9, 2'd1, 32'h100, 32'h0,    1, 32'hCAFEF00D, 1,0,1,0,1,0, 32'hCAFEF00D);
    vecs[4] = mk(1,1,1,0,0, 5'd0, 2'd0, 32'h44,  32'h99,   1, 32'h77,       0,1,1,0,0,0, 32'h77);
    vecs[5] = mk(1,0,0,0,1, 5'd2, 2'd2, 32'h8,   32'h0,    1, 32'hBAD,      0,0,1,0,1,0, 32'h0);
    vecs[6] = mk(0,0,0,0,0, 5'd1, 2'd3, 32'hC,   32'h0,    1, 32'h123,      0,0,1,0,0,0, 32'h0);

    // Reset with a live load on the EX/MEM inputs
    clr_ex();
    nRST = 0; ex_valid = 1; ex_dREN = 1; ex_addr = 32'h300; ex_WEN = 1; ex_wdatsel = 2'd1;
    ex_npc = 32'h44; dbus.dhit = 1; dbus.dmemload = 32'h9;
    #2;
    chk("rst_ren",     dbus.dmemREN, 0);
    chk("rst_en",      memwb_enable, 0);
    chk("rst_stall",   mem_stall, 0);
    chk("rst_wdatsel", wb_wdatsel, 0);
    chk("rst_port_o",  wb_port_o, 0);
    chk("rst_npc",     wb_npc, 0);
    chk("rst_wen",     wb_WEN, 0);
    chk("rst_load",    wb_dmemload, 0);
    chk("rst_halted",  halted, 0);
    chk("rst_wait",    wait_cycles, 0);
    @(negedge CLK);
    clr_ex();
    nRST = 1;
    next_cycle();

    for (int i = 0; i < 7; i++) begin
      ex_valid = vecs[i].valid; ex_dREN = vecs[i].ren; ex_dWEN = vecs[i].wen;
      ex_halt = vecs[i].halt; ex_WEN = vecs[i].rfwen; ex_wsel = vecs[i].wsel;
      ex_wdatsel = vecs[i].wdatsel; ex_addr = vecs[i].addr; ex_store = vecs[i].store;
      ex_lui_word = 32'h1000_0000 + i; ex_npc = 32'h4 * (i + 1);
      dbus.dhit = vecs[i].hit; dbus.dmemload = vecs[i].load;
      sb_q.push_back(vecs[i]);
      @(negedge CLK);
      e = sb_q.pop_front();
      chk($sformatf("v%0d_ren", i),     dbus.dmemREN, e.e_ren);
      chk($sformatf("v%0d_wen", i),     dbus.dmemWEN, e.e_wen);
      chk($sformatf("v%0d_en", i),      memwb_enable, e.e_en);
      chk($sformatf("v%0d_stall", i),   mem_stall, e.e_stall);
      chk($sformatf("v%0d_wbwen", i),   wb_WEN, e.e_wbwen);
      chk($sformatf("v%0d_wbhalt", i),  wb_halt, e.e_wbhalt);
      chk($sformatf("v%0d_port", i),    wb_port_o, e.addr);
      chk($sformatf("v%0d_load", i),    wb_dmemload, e.e_load);
      chk($sformatf("v%0d_addr", i),    dbus.dmemaddr, e.addr);
      chk($sformatf("v%0d_store", i),   dbus.dmemstore, e.store);
      chk($sformatf("v%0d_wsel", i),    wb_wsel, e.wsel);
      chk($sformatf("v%0d_wdatsel", i), wb_wdatsel, e.wdatsel);
      chk($sformatf("v%0d_lui", i),     wb_lui_word, 32'h1000_0000 + i);
      chk($sformatf("v%0d_npc", i),     wb_npc, 32'h4 * (i + 1));
      next_cycle();
    end
    clr_ex();
    @(negedge CLK);
    chk("wait_after_table", wait_cycles, 0);
    next_cycle();

    // Load with three miss cycles, then dhit
    ex_valid = 1; ex_dREN = 1; ex_WEN = 1; ex_wsel = 5'd4; ex_wdatsel = 2'd1; ex_addr = 32'h200;
    ld_q.push_back(32'hDEADBEEF);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("ld_c%0d_ren", c),   dbus.dmemREN, 1);
      chk($sformatf("ld_c%0d_stall", c), mem_stall, 1);
      chk($sformatf("ld_c%0d_en", c),    memwb_enable, 0);
      next_cycle();
    end
    dbus.dhit = 1; dbus.dmemload = 32'hDEADBEEF;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge CLK);
      if (memwb_enable) begin
        got = 1;
        chk("ld_data", wb_dmemload, ld_q.pop_front());
        chk("ld_stall_drop", mem_stall, 0);
        chk("ld_wait3", wait_cycles, 3);
      end
      next_cycle();
    end
    if (!got) chk("ld_timeout", 0, 1);

    // Follow-on load misses: enable must have been a one-cycle pulse
    ex_addr = 32'h204; dbus.dhit = 0; dbus.dmemload = 0;
    @(negedge CLK);
    chk("pulse_end_en",  memwb_enable, 0);
    chk("pulse_end_stl", mem_stall, 1);
    next_cycle();
    #2;
    nRST = 0;
    #1;
    chk("rstw_ren",    dbus.dmemREN, 0);
    chk("rstw_stall",  mem_stall, 0);
    chk("rstw_wait",   wait_cycles, 0);
    chk("rstw_halted", halted, 0);
    chk("rstw_state",  dut.state, 0);
    @(negedge CLK);
    clr_ex();
    nRST = 1;
    next_cycle();

`ifdef LL_SC_EN
    ex_valid = 1; ex_ll = 1; ex_dREN = 1; ex_addr = 32'h80; dbus.dhit = 1;
    @(negedge CLK);
    chk("ll_ren", dbus.dmemREN, 1);
    next_cycle();
    clr_ex();
    ex_valid = 1; ex_sc = 1; ex_dWEN = 1; ex_addr = 32'h80; ex_store = 32'h5; dbus.dhit = 1;
    @(negedge CLK);
    chk("sc_ok_wen",  dbus.dmemWEN, 1);
    chk("sc_ok_port", wb_port_o, 1);
    next_cycle();
    clr_ex();
    ex_valid = 1; ex_ll = 1; ex_dREN = 1; ex_addr = 32'h80; dbus.dhit = 1;
    next_cycle();
    clr_ex();
    ex_valid = 1; ex_addr = 32'h10; snoop_inv = 1; snoop_addr = 32'h80;
    next_cycle();
    clr_ex();
    ex_valid = 1; ex_sc = 1; ex_dWEN = 1; ex_addr = 32'h80; ex_store = 32'h6;
    @(negedge CLK);
    chk("sc_fail_wen",   dbus.dmemWEN, 0);
    chk("sc_fail_port",  wb_port_o, 0);
    chk("sc_fail_stall", mem_stall, 0);
    chk("sc_fail_en",    memwb_enable, 1);
    next_cycle();
    clr_ex();
`endif

    // Halt retires, then a load is suppressed
    ex_valid = 1; ex_halt = 1;
    @(negedge CLK);
    chk("halt_wbhalt", wb_halt, 1);
    chk("halt_en",     memwb_enable, 1);
    chk("halt_pre",    halted, 0);
    next_cycle();
    chk("halted_set", halted, 1);
    clr_ex();
    ex_valid = 1; ex_dREN = 1; ex_WEN = 1; ex_addr = 32'h300;
    @(negedge CLK);
    chk("hlt_ren",    dbus.dmemREN, 0);
    chk("hlt_stall",  mem_stall, 0);
    chk("hlt_en",     memwb_enable, 1);
    chk("hlt_wbhalt", wb_halt, 1);
    chk("hlt_wbwen",  wb_WEN, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller on the producing side of the MEM/WB pipeline register.
- Accepts the EX/MEM instruction and issues the data-memory request to the dcache. It holds the pipeline with a stall until the dcache returns dhit, then presents the completed write-back bundle and the enable pulse that MEM/WB latches.
- It also tracks sticky halt retirement and counts memory wait cycles.

Parameters:
- ADDR_W, 32, data address width.
- DATA_W, 32, data word width.
- WSEL_W, 5, register-file write-select width.
- CNT_W, 32, width of the wait-cycle counter.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX/MEM holds a live instruction
- ex_dREN / ex_dWEN  in  1 / 1  instruction is a load / store
- ex_addr  in  ADDR_W  ALU result, used as the memory address
- ex_store  in  DATA_W  store data
- ex_halt, ex_WEN  in  1 / 1  halt marker, register write enable
- ex_wsel  in  WSEL_W  destination register
- ex_wdatsel  in  2  write-back source select (PORT_O, DLOAD, LUI, NPC)
- ex_lui_word, ex_npc  in  DATA_W  pass-through write-back operands
- dhit  in  1  dcache access complete
- dmemload  in  DATA_W  dcache read data
- dmemREN / dmemWEN  out  1  dcache request strobes
- dmemaddr  out  ADDR_W  request address
- dmemstore  out  DATA_W  request store data
- wb_port_o, wb_dmemload, wb_lui_word, wb_npc  out  DATA_W  bundle to MEM/WB *_in
- wb_wsel  out  WSEL_W
- wb_wdatsel  out  2
- wb_WEN, wb_halt  out  1
- memwb_enable  out  1  MEM/WB capture strobe
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- halted  out  1  sticky: halt has retired
- wait_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- FSM states: IDLE, WAIT. Reset puts the FSM in IDLE.
- Reset values: halted=0, wait_cycles=0, all request strobes 0, memwb_enable=0, mem_stall=0, and every wb_* output 0 except wb_wdatsel=PORT_O.
- mem_op = ex_valid & (ex_dREN | ex_dWEN) & ~halted.
- Request strobes:
  - dmemREN = mem_op & ex_dREN; dmemWEN = mem_op & ex_dWEN.
  - Both strobes are asserted in IDLE and in WAIT.
  - dmemaddr = ex_addr; dmemstore = ex_store.
  - EX/MEM is frozen by mem_stall, so the request fields are stable for the whole access.
- IDLE:
  - Non-memory op, or mem_op with dhit in the same cycle: memwb_enable=1, mem_stall=0, remain in IDLE. This is zero added latency.
  - mem_op without dhit: memwb_enable=0, mem_stall=1, go to WAIT.
- WAIT:
  - mem_stall=1 and memwb_enable=0 until dhit.
  - On dhit: memwb_enable=1, mem_stall=0, go to IDLE.
- Write-back bundle:
  - wb_port_o=ex_addr. wb_wsel, wb_WEN, wb_wdatsel, wb_lui_word and wb_npc pass through from the matching ex_* inputs.
  - wb_dmemload=dmemload on the dhit cycle, 0 otherwise.
  - wb_halt = ex_halt & ex_valid.
  - All wb_* outputs are combinational and are sampled by MEM/WB only when memwb_enable=1.
- ex_valid=0: memwb_enable=1 with wb_WEN=0 and wb_halt=0, so a bubble propagates.
- Halt:
  - When memwb_enable=1 and wb_halt=1, halted becomes 1 on the next edge.
  - While halted=1: no requests are issued, memwb_enable=1, wb_WEN=0, wb_halt=1 held.
- A store with ex_dREN=ex_dWEN=1 is illegal; ex_dWEN takes priority and dmemREN is forced to 0.
- wait_cycles increments on every cycle with mem_stall=1 and saturates at all-ones.
- Reset mid-access: strobes drop the same instant nRST falls, the FSM returns to IDLE and the request is abandoned.
- dhit outside any request is ignored.

Optional Feature:
- Macro LL_SC_EN adds load-linked/store-conditional support with a link register (link_valid, link_addr).
- Added ports:
  - ex_ll, ex_sc  in  1
  - snoop_inv  in  1
  - snoop_addr  in  ADDR_W
- LL behaviour: an LL completing on dhit sets link_valid=1 and link_addr=ex_addr.
- SC success: link_valid=1 and link_addr=ex_addr. The store proceeds normally and the write-back value is wb_port_o=1.
- SC failure: no dmemWEN is asserted, the instruction retires in the same cycle with wb_port_o=0, and there is no stall.
- Link clearing:
  - Any retired store or SC clears link_valid.
  - snoop_inv with snoop_addr==link_addr clears link_valid.
  - A snoop invalidate wins over an LL completing in the same cycle.
  - Reset clears link_valid.
- Without the macro: these ports and the link register do not exist, and LL/SC are decoded upstream as plain load/store.

Test Plan:
- ALU op, ex_addr=0x10, ex_WEN=1, ex_wsel=3 -> memwb_enable=1 in the same cycle, wb_port_o=0x10, no strobes, mem_stall=0.
- Load addr=0x200, dhit after 3 cycles with dmemload=0xDEADBEEF:
  - dmemREN high and mem_stall=1 for 3 cycles.
  - memwb_enable pulses for exactly 1 cycle with wb_dmemload=0xDEADBEEF.
  - wait_cycles=3.
- Store addr=0x40, data=0x1234, dhit on the first cycle -> dmemWEN=1 for 1 cycle, no stall, wait_cycles unchanged.
- Halt retires -> halted=1 on the next edge. A following load with ex_dREN=1 issues no strobe, and wb_halt stays 1.
- nRST pulsed low during WAIT -> strobes go 0 immediately, FSM is in IDLE, wait_cycles=0, halted=0.
- LL_SC_EN: LL 0x80 then SC 0x80 -> SC store issued, wb_port_o=1. LL 0x80, snoop_inv with snoop_addr=0x80, then SC -> no dmemWEN, wb_port_o=0.
